// File: rtl/reg_dump_reader.sv
// reg_dump_reader: sweeps a register file read port and streams each register out as one valid/ready beat.
// Optional trailing checksum beat is enabled by defining REG_DUMP_CHECKSUM_EN.
module reg_dump_reader #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
`endif

    state_t            state;
    state_t            state_next;
    logic              handshake;
    logic              at_last;
    logic [ADDR_W-1:0] rd_addr_next;
    logic              out_valid_next;
    logic [DATA_W-1:0] out_data_next;
    logic [ADDR_W-1:0] out_addr_next;
    logic              out_last_next;
    logic              busy_next;
    logic              done_next;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    logic [DATA_W-1:0] csum_next;
`endif

    assign handshake = out_valid & out_ready;
    assign at_last   = (rd_addr == LAST_ADDR);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = READ;
            READ: state_next = SEND;
            SEND: begin
                if (handshake) begin
                    if (at_last) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = DONE;
`endif
                    end else begin
                        state_next = READ;
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: if (handshake) state_next = DONE;
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath next values; rd_addr doubles as the sweep counter
    always_comb begin
        rd_addr_next   = rd_addr;
        out_valid_next = out_valid;
        out_data_next  = out_data;
        out_addr_next  = out_addr;
        out_last_next  = out_last;
        busy_next      = (state_next != IDLE);
        done_next      = (state_next == DONE);
`ifdef REG_DUMP_CHECKSUM_EN
        csum_next      = csum;
`endif
        case (state)
            IDLE: begin
                rd_addr_next = '0;
`ifdef REG_DUMP_CHECKSUM_EN
                csum_next    = '0;
`endif
            end
            READ: begin
                out_valid_next = 1'b1;
                out_data_next  = rd_data;
                out_addr_next  = rd_addr;
`ifdef REG_DUMP_CHECKSUM_EN
                out_last_next  = 1'b0;
                csum_next      = csum + rd_data;
`else
                out_last_next  = at_last;
`endif
            end
            SEND: begin
                if (handshake) begin
                    out_valid_next = 1'b0;
                    out_last_next  = 1'b0;
                    if (!at_last) begin
                        rd_addr_next = rd_addr + ADDR_W'(1);
                    end
`ifdef REG_DUMP_CHECKSUM_EN
                    else begin
                        out_valid_next = 1'b1;
                        out_data_next  = csum;
                        out_addr_next  = '0;
                        out_last_next  = 1'b1;
                    end
`endif
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                if (handshake) begin
                    out_valid_next = 1'b0;
                    out_last_next  = 1'b0;
                end
            end
`endif
            DONE: rd_addr_next = '0;
            default: rd_addr_next = '0;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            rd_addr   <= rd_addr_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
            out_addr  <= out_addr_next;
            out_last  <= out_last_next;
            busy      <= busy_next;
            done      <= done_next;
`ifdef REG_DUMP_CHECKSUM_EN
            csum      <= csum_next;
`endif
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with a behavioural register file model.
module tb_reg_dump_reader;

    localparam int unsigned NUM = 8;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int unsigned NB = NUM + 1;
`else
    localparam int unsigned NB = NUM;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_addr;
    logic       out_last;
    logic       busy;
    logic       done;

    logic [7:0] regs  [NUM];
    logic [7:0] exp_r [NUM];
    logic [7:0] got_data [$];
    logic [2:0] got_addr [$];
    logic       got_last [$];
    int total = 0;
    int bad = 0;
    int done_cnt;
    int done_at;
    int busy_err;
    int post_err;

    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    reg_dump_reader #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_addr (out_addr),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_addr"},  32'(out_addr),  32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
    endtask

    // Run one dump; -1 disables stall / restart / write injection
    task automatic run_dump(input int stall_addr, input int restart_addr, input int write_addr);
        int  cyc;
        int  stalls;
        bit  restarted;
        bit  written;
        got_data.delete();
        got_addr.delete();
        got_last.delete();
        done_cnt = 0;
        done_at  = -1;
        busy_err = 0;
        post_err = 0;
        stalls    = 0;
        restarted = 1'b0;
        written   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (done_cnt == 0 && cyc < 200) begin
            out_ready = 1'b1;
            start     = 1'b0;
            if (!busy) busy_err++;
            if (done) begin
                done_cnt++;
                done_at = cyc;
            end else begin
                if (out_valid && int'(out_addr) == stall_addr && !out_last && stalls < 5) begin
                    out_ready = 1'b0;
                    check($sformatf("stall%0d_data", stalls), 32'(out_data), 32'(exp_r[stall_addr]));
                    stalls++;
                end
                if (out_valid && int'(out_addr) == restart_addr && !restarted) begin
                    start     = 1'b1;
                    restarted = 1'b1;
                end
                if (out_valid && int'(out_addr) == write_addr && !written) begin
                    regs[2] = 8'd99;
                    written = 1'b1;
                end
                if (out_valid && out_ready) begin
                    got_data.push_back(out_data);
                    got_addr.push_back(out_addr);
                    got_last.push_back(out_last);
                end
            end
            step();
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (busy) post_err++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) done_cnt++;
            if (busy || out_valid) post_err++;
        end
    endtask

    task automatic verify(input string name, input int exp_done_at);
        logic [7:0] sum;
        logic       exp_last;
        sum = 8'd0;
        check({name, "_beats"}, 32'(got_data.size()), 32'(NB));
        for (int i = 0; i < int'(NUM); i++) begin
            sum = sum + exp_r[i];
            if (i < got_data.size()) begin
`ifdef REG_DUMP_CHECKSUM_EN
                exp_last = 1'b0;
`else
                exp_last = (i == int'(NUM) - 1);
`endif
                check($sformatf("%s_b%0d_data", name, i), 32'(got_data[i]), 32'(exp_r[i]));
                check($sformatf("%s_b%0d_addr", name, i), 32'(got_addr[i]), 32'(i));
                check($sformatf("%s_b%0d_last", name, i), 32'(got_last[i]), 32'(exp_last));
            end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        if (got_data.size() > int'(NUM)) begin
            check({name, "_csum_data"}, 32'(got_data[NUM]), 32'(sum));
            check({name, "_csum_addr"}, 32'(got_addr[NUM]), 32'd0);
            check({name, "_csum_last"}, 32'(got_last[NUM]), 32'd1);
        end
`endif
        check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({name, "_done_at"},  32'(done_at),  32'(exp_done_at));
        check({name, "_busy_gap"}, 32'(busy_err), 32'd0);
        check({name, "_post"},     32'(post_err), 32'd0);
    endtask

    task automatic snapshot();
        for (int i = 0; i < int'(NUM); i++) exp_r[i] = regs[i];
    endtask

    initial begin
        int cyc;
        int base;
        base = int'(2 * NUM + (NB - NUM) + 1);
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < int'(NUM); i++) regs[i] = 8'(i + 10);
        step();
        step();
        check_reset_outputs("por");
        reset = 1'b1;
        step();

        // Basic dump, ready tied high
        snapshot();
        run_dump(-1, -1, -1);
        verify("basic", base);
`ifdef REG_DUMP_CHECKSUM_EN
        check("basic_csum_const", 32'(got_data.size() > 8 ? got_data[8] : 8'd0), 32'd108);
`endif

        // Backpressure on beat 3
        snapshot();
        run_dump(3, -1, -1);
        verify("bp", base + 5);

        // Start pulsed again mid-dump
        snapshot();
        run_dump(-1, 2, -1);
        verify("restart", base);

        // Reset while beat 4 is in SEND
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        out_ready = 1'b1;
        while (!(out_valid && out_addr == 3'd4) && cyc < 50) begin
            step();
            cyc++;
        end
        check("rst_reach_addr", 32'(out_addr), 32'd4);
        out_ready = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_reset_outputs("midrst");
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || out_valid || busy) done_cnt++;
        end
        check("midrst_quiet", 32'(done_cnt), 32'd0);
        snapshot();
        run_dump(-1, -1, -1);
        verify("after_rst", base);

        // Write to R2 while beat 5 is in flight
        snapshot();
        run_dump(-1, -1, 5);
        verify("cw1", base);
        check("cw_reg2", 32'(regs[2]), 32'd99);
        snapshot();
        run_dump(-1, -1, -1);
        verify("cw2", base);
        check("cw2_addr2", 32'(got_data.size() > 2 ? got_data[2] : 8'd0), 32'd99);

        // All-ones registers: checksum wraps to 0xF8
        for (int i = 0; i < int'(NUM); i++) regs[i] = 8'hFF;
        snapshot();
        run_dump(-1, -1, -1);
        verify("ones", base);
`ifdef REG_DUMP_CHECKSUM_EN
        check("ones_csum_const", 32'(got_data.size() > 8 ? got_data[8] : 8'd0), 32'hF8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Sequential reader that sweeps the register file's combinational read port and streams every register's contents out over a valid/ready interface, one beat per register, in ascending address order. It is the read-side counterpart to the register file's write port. It sits beside the register file and drives one `read_addr` port for debug dumps, state save and end-of-test comparison. It never writes the register file.

## Interface
Parameters:
- `NUM_REGS`, default 8: number of registers swept; must be ≥2.
- `ADDR_W`, default 3: width of a register address; `2**ADDR_W >= NUM_REGS`.
- `DATA_W`, default 8: register width.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset (`reset==0` at a rising edge resets the block).
- `start` input 1: request a dump; sampled only in IDLE.
- `rd_addr` output ADDR_W: drives the register file `read_addr`.
- `rd_data` input DATA_W: register file `read_val`, combinational from `rd_addr`.
- `out_valid` output 1: beat available.
- `out_ready` input 1: downstream accepts beat.
- `out_data` output DATA_W: beat payload.
- `out_addr` output ADDR_W: register index of the beat (checksum beat: 0).
- `out_last` output 1: final beat of the dump.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, READ, SEND, CSUM (only with the macro), DONE.
- IDLE: `rd_addr`=0. If `start`=1, go to READ. The address counter is already 0.
- READ: `rd_addr`=counter. Register `rd_data` into `out_data` and the counter into `out_addr`. Set `out_valid`=1, then go to SEND.
- SEND: hold all `out_*` outputs stable while `out_valid`=1 and `out_ready`=0.
  - On handshake (`out_valid` & `out_ready`), drop `out_valid`.
  - If counter==NUM_REGS-1, go to CSUM if the macro is defined, otherwise go to DONE.
  - Otherwise increment the counter and go to READ.
- CSUM: present the checksum beat with `out_valid`=1, `out_last`=1 and `out_addr`=0. Hold it until handshake, then go to DONE.
- DONE: assert `done`=1 for exactly one cycle, clear the counter, and return to IDLE.
- `out_last`=1 only on the final beat: register NUM_REGS-1, or the checksum beat if enabled.
- `start` outside IDLE is ignored. It is not queued.
- Each beat is a snapshot of `rd_data` taken in its READ cycle. A register-file write to an address that was already dumped is not reflected in the output.
- The counter never wraps past NUM_REGS-1.

## Timing
- Reset values: `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `busy`=0, `done`=0; state=IDLE; checksum=0.
- Reset is applied at the next rising edge in any state, including mid-dump. Any pending beat is dropped and no `done` pulse is produced.
- Start latency: `start` sampled at edge N gives READ during cycle N+1 and `out_valid`=1 from edge N+2.
- Each beat costs one READ cycle plus at least one SEND cycle. With `out_ready` tied high, a beat is accepted every 2 cycles.
- Minimum dump: 2·NUM_REGS cycles, plus 1 for CSUM, plus 1 DONE cycle.
- The first beat appears 2 edges after `start`. `done` rises one edge after the final handshake.
- `out_ready` may be asserted before `out_valid`. Data is transferred only on a cycle where both are high.

## Configuration
- Macro `REG_DUMP_CHECKSUM_EN`.
- Defined:
  - The checksum accumulates `rd_data` captured in each READ, as a sum mod 2^DATA_W; it is cleared in IDLE.
  - One extra CSUM beat carries the checksum. `out_last` moves to that beat.
  - The dump is NUM_REGS+1 beats.
- Undefined: no checksum register, no CSUM state, and the dump is NUM_REGS beats.

## Test plan
- Basic dump:
  - Stimulus: preload registers R[i]=i+10, `out_ready`=1, pulse `start`.
  - Required response: 8 beats with `out_data`=10..17 and `out_addr`=0..7. `out_last` is high only on addr 7. One `done` pulse occurs 17 cycles after `start`.
  - With the macro defined: a 9th beat carries `out_data`=108 (0x6C) with `out_last`=1.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles during beat 3.
  - Required response: `out_data` and `out_addr` stay stable at R3/3. No beat is lost or duplicated, and the full sequence is still 10..17.
- Wrap and overflow:
  - Stimulus: all registers preloaded with 0xFF, macro defined.
  - Required response: checksum beat = 0xF8, which is 8·255 mod 256.
- Start while busy:
  - Stimulus: pulse `start` again mid-dump.
  - Required response: the dump is unaffected and exactly one `done` pulse occurs. `busy` is 0 only after DONE.
- Reset mid-dump:
  - Stimulus: drive `reset`=0 for one edge while in SEND at beat 4.
  - Required response: the next cycle shows all outputs at their reset values and no `done` pulse. A new `start` then restarts from addr 0.
- Concurrent write:
  - Stimulus: write 99 to R2 while beat 5 is in flight.
  - Required response: beat 2 keeps its old value. A second dump reports 99 at addr 2.
